ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - pipeline execute stage with forwarding, ALU and iterative multiplier
//
// Purpose:
//   Execute stage of a 5-stage pipeline. It resolves operand forwarding from
//   EX/MEM and MEM/WB, evaluates single-cycle ALU operations, and runs a
//   32-iteration shift-add multiplier that stalls the front of the pipe.
//   Results land in the EX/MEM register driven on the *_o outputs.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   wb_i[1:0]                    [1]=RegWrite, [0]=MemtoReg
//   mem_i[2:0]                   memory-stage controls, passed through
//   alusrc_i                     1 = operand B is imm_i
//   aluop_i[1:0]                 00 add, 01 sub, 10 R-type (funct=imm_i[5:0]), 11 and
//   regdst_i                     1 = destination rdaddr_i, 0 = rtaddr_i
//   rsdata_i, rtdata_i, imm_i    register operands and sign-extended immediate
//   rsaddr_i, rtaddr_i, rdaddr_i register numbers
//   wbfwd_we_i/addr_i/data_i     MEM/WB write-back port used for forwarding
//   flush_i                      synchronous squash of EX
//   wb_o, mem_o                  EX/MEM controls
//   aluresult_o, stdata_o        EX/MEM result and store data
//   rdaddr_o                     EX/MEM destination register
//   stall_o                      hold fetch, IF/ID and ID/EX this cycle

module ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  wb_i,
  input  logic [2:0]  mem_i,
  input  logic        alusrc_i,
  input  logic [1:0]  aluop_i,
  input  logic        regdst_i,
  input  logic [31:0] rsdata_i,
  input  logic [31:0] rtdata_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rsaddr_i,
  input  logic [4:0]  rtaddr_i,
  input  logic [4:0]  rdaddr_i,
  input  logic        wbfwd_we_i,
  input  logic [4:0]  wbfwd_addr_i,
  input  logic [31:0] wbfwd_data_i,
  input  logic        flush_i,
  output logic [1:0]  wb_o,
  output logic [2:0]  mem_o,
  output logic [31:0] aluresult_o,
  output logic [31:0] stdata_o,
  output logic [4:0]  rdaddr_o,
  output logic        stall_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h18;

  state_t      r_state;
  state_t      w_state_nxt;

  // EX/MEM register
  logic [1:0]  r_wb;
  logic [2:0]  r_mem;
  logic [31:0] r_res;
  logic [31:0] r_st;
  logic [4:0]  r_rd;

  // Multiplier working state, frozen copies of the mul instruction's fields
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [1:0]  r_cap_wb;
  logic [2:0]  r_cap_mem;
  logic [31:0] r_cap_st;
  logic [4:0]  r_cap_rd;

  logic        w_fwd_a_exmem;
  logic        w_fwd_a_memwb;
  logic        w_fwd_b_exmem;
  logic        w_fwd_b_memwb;
  logic        w_exmem_can_fwd;
  logic [31:0] w_op_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_op_b;
  logic [4:0]  w_dest;
  logic [5:0]  w_funct;
  logic        w_is_mul;
  logic [31:0] w_alu;
  logic [31:0] w_acc_nxt;
  logic        w_stall;
  logic        w_last_iter;

  // ---------------------------------------------------------------------------
  // Forwarding. A load in EX/MEM (MemtoReg=1) has no data yet, so it is never a
  // forwarding source. Register 0 is hard-wired zero and never matches.
  // ---------------------------------------------------------------------------
  assign w_exmem_can_fwd = r_wb[1] & ~r_wb[0] & (r_rd != 5'd0);

  assign w_fwd_a_exmem = w_exmem_can_fwd & (r_rd == rsaddr_i);
  assign w_fwd_a_memwb = wbfwd_we_i & (wbfwd_addr_i != 5'd0) & (wbfwd_addr_i == rsaddr_i);
  assign w_fwd_b_exmem = w_exmem_can_fwd & (r_rd == rtaddr_i);
  assign w_fwd_b_memwb = wbfwd_we_i & (wbfwd_addr_i != 5'd0) & (wbfwd_addr_i == rtaddr_i);

  assign w_op_a  = w_fwd_a_exmem ? r_res :
                   w_fwd_a_memwb ? wbfwd_data_i : rsdata_i;
  assign w_fwd_b = w_fwd_b_exmem ? r_res :
                   w_fwd_b_memwb ? wbfwd_data_i : rtdata_i;
  assign w_op_b  = alusrc_i ? imm_i : w_fwd_b;

  assign w_dest   = regdst_i ? rdaddr_i : rtaddr_i;
  assign w_funct  = imm_i[5:0];
  assign w_is_mul = (aluop_i == 2'b10) && (w_funct == FN_MUL);

  // ---------------------------------------------------------------------------
  // Single-cycle ALU. Mul is handled by the iterative unit; its funct falls
  // into the default arm here and the value is never registered.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_alu = 32'd0;
    case (aluop_i)
      2'b00: w_alu = w_op_a + w_op_b;
      2'b01: w_alu = w_op_a - w_op_b;
      2'b11: w_alu = w_op_a & w_op_b;
      default: begin
        case (w_funct)
          FN_ADD:  w_alu = w_op_a + w_op_b;
          FN_SUB:  w_alu = w_op_a - w_op_b;
          FN_AND:  w_alu = w_op_a & w_op_b;
          FN_OR:   w_alu = w_op_a | w_op_b;
          FN_SLT:  w_alu = {31'd0, ($signed(w_op_a) < $signed(w_op_b))};
          default: w_alu = 32'd0;
        endcase
      end
    endcase
  end

  // One shift-add step; on the last iteration this is the full product.
  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
  assign w_last_iter = (r_cnt == 5'd31);

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state/stall logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mul) begin
          w_stall     = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        // Release the front end during the final iteration so the next
        // instruction enters ID/EX on the same edge the product is written.
        w_stall = ~w_last_iter;
        if (w_last_iter) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt = S_IDLE;
      w_stall     = 1'b0;
    end
    // The state register is already IDLE during reset, but a mul sitting on
    // the inputs would otherwise still raise stall.
    if (rst_i) begin
      w_stall = 1'b0;
    end
  end

  assign stall_o = w_stall;

  // ---------------------------------------------------------------------------
  // EX/MEM register and multiplier datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wb      <= 2'd0;
      r_mem     <= 3'd0;
      r_res     <= 32'd0;
      r_st      <= 32'd0;
      r_rd      <= 5'd0;
      r_cnt     <= 5'd0;
      r_acc     <= 32'd0;
      r_mcand   <= 32'd0;
      r_mplier  <= 32'd0;
      r_cap_wb  <= 2'd0;
      r_cap_mem <= 3'd0;
      r_cap_st  <= 32'd0;
      r_cap_rd  <= 5'd0;
    end else if (flush_i) begin
      // Squash: bubble into EX/MEM, any in-flight mul is dropped.
      r_wb  <= 2'd0;
      r_mem <= 3'd0;
      r_cnt <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul) begin
            r_mcand   <= w_op_a;
            r_mplier  <= w_op_b;
            r_acc     <= 32'd0;
            r_cnt     <= 5'd0;
            r_cap_wb  <= wb_i;
            r_cap_mem <= mem_i;
            r_cap_st  <= w_fwd_b;
            r_cap_rd  <= w_dest;
            r_wb      <= 2'd0;
            r_mem     <= 3'd0;
          end else begin
            r_wb  <= wb_i;
            r_mem <= mem_i;
            r_res <= w_alu;
            r_st  <= w_fwd_b;
            r_rd  <= w_dest;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= {r_mcand[30:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_cnt    <= r_cnt + 5'd1;
          if (w_last_iter) begin
            r_wb  <= r_cap_wb;
            r_mem <= r_cap_mem;
            r_res <= w_acc_nxt;
            r_st  <= r_cap_st;
            r_rd  <= r_cap_rd;
          end else begin
            r_wb  <= 2'd0;
            r_mem <= 3'd0;
          end
        end
        default: begin
          r_wb  <= 2'd0;
          r_mem <= 3'd0;
        end
      endcase
    end
  end

  assign wb_o        = r_wb;
  assign mem_o       = r_mem;
  assign aluresult_o = r_res;
  assign stdata_o    = r_st;
  assign rdaddr_o    = r_rd;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard testbench for ex_stage

module tb_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  wb_i;
  logic [2:0]  mem_i;
  logic        alusrc_i;
  logic [1:0]  aluop_i;
  logic        regdst_i;
  logic [31:0] rsdata_i, rtdata_i, imm_i;
  logic [4:0]  rsaddr_i, rtaddr_i, rdaddr_i;
  logic        wbfwd_we_i;
  logic [4:0]  wbfwd_addr_i;
  logic [31:0] wbfwd_data_i;
  logic        flush_i;
  logic [1:0]  wb_o;
  logic [2:0]  mem_o;
  logic [31:0] aluresult_o, stdata_o;
  logic [4:0]  rdaddr_o;
  logic        stall_o;

  ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_i(wb_i), .mem_i(mem_i),
    .alusrc_i(alusrc_i), .aluop_i(aluop_i), .regdst_i(regdst_i),
    .rsdata_i(rsdata_i), .rtdata_i(rtdata_i), .imm_i(imm_i),
    .rsaddr_i(rsaddr_i), .rtaddr_i(rtaddr_i), .rdaddr_i(rdaddr_i),
    .wbfwd_we_i(wbfwd_we_i), .wbfwd_addr_i(wbfwd_addr_i), .wbfwd_data_i(wbfwd_data_i),
    .flush_i(flush_i), .wb_o(wb_o), .mem_o(mem_o), .aluresult_o(aluresult_o),
    .stdata_o(stdata_o), .rdaddr_o(rdaddr_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        chk_res;
    logic        chk_st;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t bubble(input string nm);
    exp_t e;
    e.name = nm; e.chk_res = 1'b0; e.chk_st = 1'b0;
    e.wb = 2'd0; e.mem = 3'd0; e.res = 32'd0; e.st = 32'd0; e.rd = 5'd0;
    return e;
  endfunction

  function automatic exp_t result(input string nm, input logic [1:0] wb, input logic [2:0] mem,
                                  input logic [31:0] res, input logic [4:0] rd,
                                  input logic chk_st, input logic [31:0] st);
    exp_t e;
    e.name = nm; e.chk_res = 1'b1; e.chk_st = chk_st;
    e.wb = wb; e.mem = mem; e.res = res; e.st = st; e.rd = rd;
    return e;
  endfunction

  // Monitor: every edge with a pending expectation is compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, " wb"}, {30'd0, wb_o}, {30'd0, e.wb});
        chk({e.name, " mem"}, {29'd0, mem_o}, {29'd0, e.mem});
        if (e.chk_res) begin
          chk({e.name, " result"}, aluresult_o, e.res);
          chk({e.name, " rdaddr"}, {27'd0, rdaddr_o}, {27'd0, e.rd});
        end
        if (e.chk_st) chk({e.name, " stdata"}, stdata_o, e.st);
      end
    end
  end

  task automatic set_op(input logic [1:0] wb, input logic [2:0] mem, input logic alusrc,
                        input logic [1:0] aluop, input logic regdst,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
    wb_i = wb; mem_i = mem; alusrc_i = alusrc; aluop_i = aluop; regdst_i = regdst;
    rsaddr_i = rs; rtaddr_i = rt; rdaddr_i = rd;
    rsdata_i = rsd; rtdata_i = rtd; imm_i = imm;
  endtask

  // Entered at a falling edge with inputs already driven.
  task automatic step(input string nm, input logic exp_stall, input exp_t e);
    #1;
    chk({nm, " stall"}, {31'd0, stall_o}, {31'd0, exp_stall});
    q.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [1:0] wb, input logic [2:0] mem,
                         input logic [31:0] prod);
    wbfwd_we_i = 1'b0;
    set_op(wb, mem, 1'b0, 2'b10, 1'b1, 5'd1, 5'd2, rd, a, b, 32'h18);
    step({nm, " start"}, 1'b1, bubble({nm, " start"}));
    // Inputs and MEM/WB change under the running mul and must be ignored.
    set_op(2'b10, 3'b111, 1'b0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF, 32'h1234, 32'h0);
    wbfwd_we_i = 1'b1; wbfwd_addr_i = 5'd1; wbfwd_data_i = 32'd123;
    for (int i = 1; i < 32; i++) step({nm, " iter"}, 1'b1, bubble({nm, " iter"}));
    step({nm, " final"}, 1'b0, result({nm, " product"}, wb, mem, prod, rd, 1'b0, 32'd0));
    wbfwd_we_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    wbfwd_we_i = 1'b0; wbfwd_addr_i = 5'd0; wbfwd_data_i = 32'd0;
    set_op(2'd0, 3'd0, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk_i);
    chk("reset wb", {30'd0, wb_o}, 32'd0);
    chk("reset mem", {29'd0, mem_o}, 32'd0);
    chk("reset result", aluresult_o, 32'd0);
    chk("reset stdata", stdata_o, 32'd0);
    chk("reset rdaddr", {27'd0, rdaddr_o}, 32'd0);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    rst_i = 1'b0;

    // Basic add and forwarding chain
    set_op(2'b10, 3'b101, 1'b0, 2'b00, 1'b1, 5'd5, 5'd6, 5'd8, 32'd7, 32'd3, 32'd0);
    step("add", 1'b0, result("add", 2'b10, 3'b101, 32'd10, 5'd8, 1'b1, 32'd3));
    set_op(2'b10, 3'b000, 1'b0, 2'b01, 1'b1, 5'd8, 5'd9, 5'd10, 32'd99, 32'd4, 32'd0);
    wbfwd_we_i = 1'b1; wbfwd_addr_i = 5'd8; wbfwd_data_i = 32'd50;
    step("sub exmem fwd", 1'b0, result("sub exmem fwd", 2'b10, 3'b000, 32'd6, 5'd10, 1'b1, 32'd4));
    set_op(2'b11, 3'b010, 1'b0, 2'b00, 1'b1, 5'd8, 5'd10, 5'd12, 32'd1, 32'd100, 32'd0);
    step("add both fwd", 1'b0, result("add both fwd", 2'b11, 3'b010, 32'd56, 5'd12, 1'b1, 32'd6));
    set_op(2'b10, 3'b000, 1'b0, 2'b00, 1'b1, 5'd12, 5'd0, 5'd13, 32'd7, 32'd0, 32'd0);
    wbfwd_addr_i = 5'd0; wbfwd_data_i = 32'd77;
    step("no fwd load/r0", 1'b0, result("no fwd load/r0", 2'b10, 3'b000, 32'd7, 5'd13, 1'b1, 32'd0));
    wbfwd_we_i = 1'b0;

    // ALU operation table
    set_op(2'b01, 3'b010, 1'b1, 2'b11, 1'b0, 5'd1, 5'd2, 5'd9, 32'hF0F0, 32'h1234, 32'hFF00);
    step("and imm", 1'b0, result("and imm", 2'b01, 3'b010, 32'hF000, 5'd2, 1'b1, 32'h1234));
    set_op(2'b10, 3'b000, 1'b0, 2'b10, 1'b1, 5'd1, 5'd2, 5'd3, 32'hF0, 32'h0F, 32'h25);
    step("or", 1'b0, result("or", 2'b10, 3'b000, 32'hFF, 5'd3, 1'b0, 32'd0));
    set_op(2'b10, 3'b000, 1'b0, 2'b10, 1'b1, 5'd4, 5'd5, 5'd6, 32'hFFFF_FFFE, 32'd1, 32'h2A);
    step("slt neg", 1'b0, result("slt neg", 2'b10, 3'b000, 32'd1, 5'd6, 1'b0, 32'd0));
    set_op(2'b10, 3'b000, 1'b0, 2'b10, 1'b1, 5'd4, 5'd5, 5'd6, 32'd1, 32'hFFFF_FFFE, 32'h2A);
    step("slt pos", 1'b0, result("slt pos", 2'b10, 3'b000, 32'd0, 5'd6, 1'b0, 32'd0));
    set_op(2'b10, 3'b000, 1'b0, 2'b10, 1'b1, 5'd4, 5'd5, 5'd7, 32'd5, 32'd7, 32'h22);
    step("rsub", 1'b0, result("rsub", 2'b10, 3'b000, 32'hFFFF_FFFE, 5'd7, 1'b0, 32'd0));
    set_op(2'b10, 3'b000, 1'b0, 2'b10, 1'b1, 5'd4, 5'd5, 5'd9, 32'd5, 32'd7, 32'h3F);
    step("bad funct", 1'b0, result("bad funct", 2'b10, 3'b000, 32'd0, 5'd9, 1'b0, 32'd0));
    set_op(2'b10, 3'b001, 1'b1, 2'b00, 1'b1, 5'd4, 5'd5, 5'd11, 32'd10, 32'd0, 32'hFFFF_FFFC);
    step("addi neg", 1'b0, result("addi neg", 2'b10, 3'b001, 32'd6, 5'd11, 1'b0, 32'd0));

    // Multiplier
    run_mul("mul wrap", 32'hFFFF_FFFF, 32'd3, 5'd14, 2'b10, 3'b001, 32'hFFFF_FFFD);
    run_mul("mul r0", 32'd12345, 32'd1000, 5'd0, 2'b10, 3'b000, 32'd12345000);

    // Flush: in IDLE over an add, over a decoded mul, and mid-mul
    set_op(2'b10, 3'b111, 1'b0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0);
    flush_i = 1'b1;
    step("flush add", 1'b0, bubble("flush add"));
    set_op(2'b10, 3'b111, 1'b0, 2'b10, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd5, 32'h18);
    step("flush mul idle", 1'b0, bubble("flush mul idle"));
    flush_i = 1'b0;
    step("mul for flush", 1'b1, bubble("mul for flush"));
    for (int i = 0; i < 10; i++) step("mul pre-flush", 1'b1, bubble("mul pre-flush"));
    flush_i = 1'b1;
    step("flush mid mul", 1'b0, bubble("flush mid mul"));
    flush_i = 1'b0;
    set_op(2'b10, 3'b000, 1'b0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd3, 32'd2, 32'd3, 32'd0);
    step("add after flush", 1'b0, result("add after flush", 2'b10, 3'b000, 32'd5, 5'd3, 1'b0, 32'd0));
    set_op(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    step("nop after flush", 1'b0, bubble("nop after flush"));

    // Asynchronous reset in the middle of a mul
    set_op(2'b10, 3'b000, 1'b0, 2'b10, 1'b1, 5'd1, 5'd2, 5'd3, 32'd100, 32'd3, 32'h18);
    step("mul for reset", 1'b1, bubble("mul for reset"));
    for (int i = 0; i < 4; i++) step("mul pre-reset", 1'b1, bubble("mul pre-reset"));
    #2 rst_i = 1'b1;
    #1;
    chk("async rst wb", {30'd0, wb_o}, 32'd0);
    chk("async rst mem", {29'd0, mem_o}, 32'd0);
    chk("async rst result", aluresult_o, 32'd0);
    chk("async rst stdata", stdata_o, 32'd0);
    chk("async rst rdaddr", {27'd0, rdaddr_o}, 32'd0);
    chk("async rst stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_mul("mul after reset", 32'd7, 32'd9, 5'd20, 2'b10, 3'b100, 32'd63);

    set_op(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk_i);
    chk("scoreboard drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
